// File: rtl/xp_vc_input_buffer.sv
// ---------------------------------------------------------------------------
// xp_vc_input_buffer
//   Receive-side stage of a crosspoint router port. Incoming flits are stored
//   in one circular FIFO per virtual channel. A round-robin arbiter picks a
//   non-empty VC for the downstream route/switch stage. One credit goes back
//   upstream, one cycle after each flit leaves.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_flit  : upstream flit and its VC (in_vc_id)
//   in_ready          : !full of the addressed VC (informational; the sender
//                       is credit-limited)
//   out_valid/out_ready, out_flit, out_vc_id : granted head flit toward the
//                       switch stage
//   out_channel_type  : constant channel tag (00 REQ, 01 RSP, 10 DAT, 11 SNP)
//   crd_rtn, crd_rtn_vc : one-cycle credit pulse per dequeued flit
//   occupancy         : per-VC entry counts, VC0 in the LSBs
//   overflow_err      : sticky; a flit arrived for a full VC and was dropped
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Once out_valid is high it stays high, and out_vc_id/out_flit hold,
// until out_ready is seen. The upstream side is credit-based, so in_ready is
// advisory only. A flit offered to a full VC is dropped and flagged.
// ---------------------------------------------------------------------------
module xp_vc_input_buffer #(
   parameter int          FLIT_W       = 64,
   parameter int          NUM_VC       = 4,
   parameter int          DEPTH        = 4,
   parameter logic [1:0]  CHANNEL_TYPE = 2'b00
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [FLIT_W-1:0]                     in_flit,
   input  logic [1:0]                            in_vc_id,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [FLIT_W-1:0]                     out_flit,
   output logic [1:0]                            out_vc_id,
   output logic [1:0]                            out_channel_type,
   output logic                                  crd_rtn,
   output logic [1:0]                            crd_rtn_vc,
   output logic [NUM_VC*$clog2(DEPTH+1)-1:0]     occupancy,
   output logic                                  overflow_err
);

   localparam int VC_W  = 2;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [FLIT_W-1:0] mem    [NUM_VC][DEPTH];
   logic [PTR_W-1:0]  wr_ptr [NUM_VC];
   logic [PTR_W-1:0]  rd_ptr [NUM_VC];
   logic [CNT_W-1:0]  count  [NUM_VC];

   logic [VC_W-1:0]   rr_ptr;
   logic              lock_valid;
   logic [VC_W-1:0]   lock_vc;
   logic [VC_W-1:0]   cand_vc;
   logic [VC_W-1:0]   grant_vc;
   logic [NUM_VC-1:0] nonempty;
   logic [NUM_VC-1:0] vc_push;
   logic [NUM_VC-1:0] vc_pop;
   logic              enq;
   logic              deq;

   // Readiness is taken from the pre-dequeue count. A full VC therefore
   // refuses a write in the same cycle it drains; there is no full-bypass.
   assign in_ready = (count[in_vc_id] != CNT_W'(DEPTH));
   assign enq      = in_valid && in_ready;

   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         nonempty[v] = (count[v] != '0);
      end
   end

   // First non-empty VC, scanning from rr_ptr upward modulo NUM_VC.
   always_comb begin
      int idx;
      logic found;
      cand_vc = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < NUM_VC; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_VC;
         if (!found && nonempty[idx]) begin
            found   = 1'b1;
            cand_vc = VC_W'(idx);
         end
      end
   end

   // A stalled grant stays put even if a higher-priority VC fills meanwhile.
   // The locked VC cannot empty while locked, since only a dequeue drains it.
   assign grant_vc  = lock_valid ? lock_vc : cand_vc;
   assign out_valid = |nonempty;
   assign out_vc_id = out_valid ? grant_vc : '0;
   assign out_flit  = mem[grant_vc][rd_ptr[grant_vc]];
   assign deq       = out_valid && out_ready;

   assign out_channel_type = CHANNEL_TYPE;

   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         vc_push[v] = enq && (in_vc_id == VC_W'(v));
         vc_pop[v]  = deq && (grant_vc == VC_W'(v));
      end
   end

   // Flit storage is not reset; the counts decide what is valid.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[in_vc_id][wr_ptr[in_vc_id]] <= in_flit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
            count[v]  <= '0;
         end
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (vc_push[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
            if (vc_pop[v])  rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
            if (vc_push[v] && !vc_pop[v]) begin
               count[v] <= count[v] + CNT_W'(1);
            end else if (vc_pop[v] && !vc_push[v]) begin
               count[v] <= count[v] - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         lock_valid   <= 1'b0;
         lock_vc      <= '0;
         crd_rtn      <= 1'b0;
         crd_rtn_vc   <= '0;
         overflow_err <= 1'b0;
      end else begin
         crd_rtn <= deq;
         if (deq) begin
            crd_rtn_vc <= grant_vc;
            rr_ptr     <= (grant_vc == VC_W'(NUM_VC-1)) ? '0 : grant_vc + VC_W'(1);
            lock_valid <= 1'b0;
         end else if (out_valid) begin
            lock_valid <= 1'b1;
            lock_vc    <= grant_vc;
         end
         if (in_valid && !in_ready) begin
            overflow_err <= 1'b1;
         end
      end
   end

   always_comb begin
      occupancy = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         occupancy[v*CNT_W +: CNT_W] = count[v];
      end
   end

endmodule

// File: tb/tb_xp_vc_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_xp_vc_input_buffer
//   Self-checking bench for xp_vc_input_buffer (FLIT_W=16, NUM_VC=4, DEPTH=4).
//   Table vectors hold hand-derived expectations. Every cycle is also checked
//   against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_xp_vc_input_buffer;

   localparam int FW    = 16;
   localparam int NVC   = 4;
   localparam int DEP   = 4;
   localparam int CW    = 3;
   localparam int OCC_W = NVC*CW;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [FW-1:0]    in_flit;
   logic [1:0]       in_vc_id;
   logic             out_valid;
   logic             out_ready;
   logic [FW-1:0]    out_flit;
   logic [1:0]       out_vc_id;
   logic [1:0]       out_channel_type;
   logic             crd_rtn;
   logic [1:0]       crd_rtn_vc;
   logic [OCC_W-1:0] occupancy;
   logic             overflow_err;

   int checks   = 0;
   int failures = 0;

   xp_vc_input_buffer #(
      .FLIT_W(FW), .NUM_VC(NVC), .DEPTH(DEP), .CHANNEL_TYPE(2'b10)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit), .in_vc_id(in_vc_id),
      .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
      .out_vc_id(out_vc_id), .out_channel_type(out_channel_type),
      .crd_rtn(crd_rtn), .crd_rtn_vc(crd_rtn_vc),
      .occupancy(occupancy), .overflow_err(overflow_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [FW-1:0] mq [NVC][$];
   int            m_rr;
   bit            m_lock;
   int            m_lock_vc;
   bit            m_crd;
   int            m_crd_vc;
   bit            m_ovf;

   function automatic void model_clear();
      for (int v = 0; v < NVC; v++) mq[v].delete();
      m_rr = 0; m_lock = 0; m_lock_vc = 0; m_crd = 0; m_crd_vc = 0; m_ovf = 0;
   endfunction

   function automatic bit m_any();
      for (int v = 0; v < NVC; v++) if (mq[v].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_grant();
      if (m_lock) return m_lock_vc;
      for (int i = 0; i < NVC; i++) begin
         if (mq[(m_rr + i) % NVC].size() != 0) return (m_rr + i) % NVC;
      end
      return 0;
   endfunction

   function automatic logic [OCC_W-1:0] m_occ();
      logic [OCC_W-1:0] o;
      o = '0;
      for (int v = 0; v < NVC; v++) o[v*CW +: CW] = CW'(mq[v].size());
      return o;
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] vc, input logic [FW-1:0] f,
                        input logic rdy);
      in_valid  = v;
      in_vc_id  = vc;
      in_flit   = f;
      out_ready = rdy;
      #1;
   endtask

   task automatic model_check();
      bit ev;
      int g;
      ev = m_any();
      g  = m_grant();
      check("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
         check("out_vc_id", 32'(out_vc_id), 32'(g));
         check("out_flit", 32'(out_flit), 32'(mq[g][0]));
      end
      check("in_ready", 32'(in_ready), 32'(mq[in_vc_id].size() < DEP));
      check("occupancy", 32'(occupancy), 32'(m_occ()));
      check("overflow_err", 32'(overflow_err), 32'(m_ovf));
      check("crd_rtn", 32'(crd_rtn), 32'(m_crd));
      if (m_crd) check("crd_rtn_vc", 32'(crd_rtn_vc), 32'(m_crd_vc));
      check("out_channel_type", 32'(out_channel_type), 32'h2);
   endtask

   // Advances the model by the edge about to happen, then waits for it.
   task automatic model_step();
      bit ev, hs, acc;
      int g;
      ev  = m_any();
      g   = m_grant();
      hs  = ev && out_ready;
      acc = in_valid && (mq[in_vc_id].size() < DEP);
      if (in_valid && !acc) m_ovf = 1'b1;
      if (hs) void'(mq[g].pop_front());
      if (acc) mq[in_vc_id].push_back(in_flit);
      m_crd = hs;
      if (hs) begin
         m_crd_vc = g;
         m_rr     = (g + 1) % NVC;
         m_lock   = 1'b0;
      end else if (ev) begin
         m_lock    = 1'b1;
         m_lock_vc = g;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic v, input logic [1:0] vc, input logic [FW-1:0] f,
                        input logic rdy);
      drive(v, vc, f, rdy);
      model_check();
      model_step();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
   task automatic do_reset();
      in_valid = 0; out_ready = 0; in_vc_id = 0; in_flit = '0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(out_valid), 32'h0);
      check("rst occupancy", 32'(occupancy), 32'h0);
      check("rst crd_rtn", 32'(crd_rtn), 32'h0);
      check("rst in_ready", 32'(in_ready), 32'h1);
      check("rst out_vc_id", 32'(out_vc_id), 32'h0);
      check("rst overflow_err", 32'(overflow_err), 32'h0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic             v;
      logic [1:0]       vc;
      logic [FW-1:0]    f;
      logic             rdy;
      logic             e_valid;
      logic [1:0]       e_vc;
      logic [FW-1:0]    e_flit;
      logic             e_in_ready;
      logic [OCC_W-1:0] e_occ;
      logic             e_crd;
      logic [1:0]       e_crd_vc;
      logic             e_ovf;
   } vec_t;

   vec_t tab [16];

   function automatic vec_t mk(logic v, logic [1:0] vc, logic [FW-1:0] f, logic rdy,
                               logic ev, logic [1:0] evc, logic [FW-1:0] ef, logic eir,
                               logic [OCC_W-1:0] eo, logic ec, logic [1:0] ecv, logic eov);
      vec_t t;
      t.v = v; t.vc = vc; t.f = f; t.rdy = rdy;
      t.e_valid = ev; t.e_vc = evc; t.e_flit = ef; t.e_in_ready = eir;
      t.e_occ = eo; t.e_crd = ec; t.e_crd_vc = ecv; t.e_ovf = eov;
      return t;
   endfunction

   logic [1:0] exp_q [$];
   logic [1:0] got_q [$];
   logic [1:0] crd_q [$];
   logic [FW-1:0] held_flit;

   initial begin
      // single flit on VC2, then fill/overflow VC1 and drain it
      tab[0]  = mk(1, 2, 16'h00A5, 1,  0, 0, 16'h0,  1, 12'h000, 0, 0, 0);
      tab[1]  = mk(0, 2, 16'h0000, 1,  1, 2, 16'hA5, 1, 12'h040, 0, 0, 0);
      tab[2]  = mk(0, 2, 16'h0000, 1,  0, 0, 16'h0,  1, 12'h000, 1, 2, 0);
      tab[3]  = mk(0, 1, 16'h0000, 0,  0, 0, 16'h0,  1, 12'h000, 0, 0, 0);
      tab[4]  = mk(1, 1, 16'h0011, 0,  0, 0, 16'h0,  1, 12'h000, 0, 0, 0);
      tab[5]  = mk(1, 1, 16'h0012, 0,  1, 1, 16'h11, 1, 12'h008, 0, 0, 0);
      tab[6]  = mk(1, 1, 16'h0013, 0,  1, 1, 16'h11, 1, 12'h010, 0, 0, 0);
      tab[7]  = mk(1, 1, 16'h0014, 0,  1, 1, 16'h11, 1, 12'h018, 0, 0, 0);
      tab[8]  = mk(1, 1, 16'h0015, 0,  1, 1, 16'h11, 0, 12'h020, 0, 0, 0);
      tab[9]  = mk(0, 1, 16'h0000, 0,  1, 1, 16'h11, 0, 12'h020, 0, 0, 1);
      tab[10] = mk(0, 1, 16'h0000, 1,  1, 1, 16'h11, 0, 12'h020, 0, 0, 1);
      tab[11] = mk(0, 1, 16'h0000, 1,  1, 1, 16'h12, 1, 12'h018, 1, 1, 1);
      tab[12] = mk(0, 1, 16'h0000, 1,  1, 1, 16'h13, 1, 12'h010, 1, 1, 1);
      tab[13] = mk(0, 1, 16'h0000, 1,  1, 1, 16'h14, 1, 12'h008, 1, 1, 1);
      tab[14] = mk(0, 1, 16'h0000, 1,  0, 0, 16'h0,  1, 12'h000, 1, 1, 1);
      tab[15] = mk(0, 1, 16'h0000, 0,  0, 0, 16'h0,  1, 12'h000, 0, 0, 1);

      rst_n = 1'b0; in_valid = 0; in_flit = '0; in_vc_id = 0; out_ready = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 16; i++) begin
         drive(tab[i].v, tab[i].vc, tab[i].f, tab[i].rdy);
         check($sformatf("tab%0d out_valid", i), 32'(out_valid), 32'(tab[i].e_valid));
         if (tab[i].e_valid) begin
            check($sformatf("tab%0d out_vc_id", i), 32'(out_vc_id), 32'(tab[i].e_vc));
            check($sformatf("tab%0d out_flit", i), 32'(out_flit), 32'(tab[i].e_flit));
         end
         check($sformatf("tab%0d in_ready", i), 32'(in_ready), 32'(tab[i].e_in_ready));
         check($sformatf("tab%0d occupancy", i), 32'(occupancy), 32'(tab[i].e_occ));
         check($sformatf("tab%0d crd_rtn", i), 32'(crd_rtn), 32'(tab[i].e_crd));
         if (tab[i].e_crd)
            check($sformatf("tab%0d crd_rtn_vc", i), 32'(crd_rtn_vc), 32'(tab[i].e_crd_vc));
         check($sformatf("tab%0d overflow_err", i), 32'(overflow_err), 32'(tab[i].e_ovf));
         model_check();
         model_step();
      end

      // round-robin: two flits per VC, then drain
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, 2'(i % 4), 16'(16'h100 + i), 0);
      for (int i = 0; i < 8; i++) exp_q.push_back(2'(i % 4));
      got_q.delete(); crd_q.delete();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, '0, 1);
         if (out_valid) got_q.push_back(out_vc_id);
         if (crd_rtn) crd_q.push_back(crd_rtn_vc);
         model_check();
         model_step();
      end
      check("rr grant count", 32'(got_q.size()), 32'(8));
      check("rr credit count", 32'(crd_q.size()), 32'(8));
      for (int i = 0; i < 8; i++) begin
         check($sformatf("rr grant%0d", i), 32'(i < got_q.size() ? got_q[i] : 2'bxx), 32'(exp_q[i]));
         check($sformatf("rr credit%0d", i), 32'(i < crd_q.size() ? crd_q[i] : 2'bxx), 32'(exp_q[i]));
      end
      exp_q.delete();

      // grant lock: VC3 stalled while VC0 fills
      do_reset();
      cycle(1, 3, 16'h3333, 0);
      drive(1, 0, 16'h0A00, 0);
      held_flit = out_flit;
      model_check(); model_step();
      for (int i = 1; i < 3; i++) begin
         drive(1, 0, 16'(16'h0A00 + i), 0);
         check("lock out_vc_id", 32'(out_vc_id), 32'h3);
         check("lock out_flit", 32'(out_flit), 32'(held_flit));
         model_check(); model_step();
      end
      drive(0, 0, '0, 1);
      check("lock handshake vc", 32'(out_vc_id), 32'h3);
      model_check(); model_step();
      drive(0, 0, '0, 1);
      check("after lock next vc", 32'(out_vc_id), 32'h0);
      model_check(); model_step();
      for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);

      // wrap and full-drain on VC0
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 0, 16'(16'hB00 + i), 0);
      drive(1, 0, 16'hBFF, 1);
      check("full drain in_ready", 32'(in_ready), 32'h0);
      model_check(); model_step();
      for (int i = 0; i < 12; i++) cycle(1, 0, 16'(16'hC00 + i), 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1);

      // randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 3) != 0));
      end

      // asynchronous reset with three flits held
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1, 2, 16'(16'hD00 + i), 0);
      cycle(0, 2, '0, 0);
      do_reset();
      for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xp_vc_input_buffer.md
# xp_vc_input_buffer

Receive-side stage of a crosspoint router port. Accepts flits from the upstream XP port link, stores them in per-virtual-channel FIFOs, arbitrates round-robin among non-empty VCs toward the downstream route/switch stage, and returns one credit per dequeued flit to the upstream sender. One instance per channel type (REQ, RSP, DAT, SNP).

## Interface
Parameters:
- FLIT_W, $bits(flit_u) from coh_noc_pkg: flit width.
- NUM_VC, 4: virtual channels. Must match the 2-bit vc_id field.
- DEPTH, 4: entries per VC. Power of two, at least 2.
- CHANNEL_TYPE, 2'b00: channel tag driven on out_channel_type (00 REQ, 01 RSP, 10 DAT, 11 SNP).

Ports:
- clk, input, 1: sole clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: upstream flit present.
- in_ready, output, 1: !full[in_vc_id]. Informational only, because the sender is credit-limited.
- in_flit, input, FLIT_W: upstream flit.
- in_vc_id, input, 2: VC of in_flit.
- out_valid, output, 1: a granted flit is presented.
- out_ready, input, 1: downstream accepts.
- out_flit, output, FLIT_W: head flit of the granted VC.
- out_vc_id, output, 2: granted VC.
- out_channel_type, output, 2: constant CHANNEL_TYPE.
- crd_rtn, output, 1: credit-return pulse, one per dequeued flit.
- crd_rtn_vc, output, 2: VC of the returned credit.
- occupancy, output, NUM_VC*$clog2(DEPTH+1): per-VC entry counts, VC0 in the LSBs.
- overflow_err, output, 1: sticky. Set when a flit arrives while its VC is full.

## Operation
- Storage: NUM_VC circular FIFOs. Each has wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and count (0..DEPTH). full = (count==DEPTH). empty = (count==0).
- Enqueue: when in_valid && in_ready, write in_flit at wr_ptr[in_vc_id], then increment that pointer and count.
- Overflow: when in_valid && !in_ready, the flit is dropped, no state changes, and overflow_err is set until reset.
- Arbitration:
  - rr_ptr (2 bits) gives the highest-priority VC.
  - The candidate is the first non-empty VC scanning rr_ptr, rr_ptr+1, … modulo NUM_VC.
  - out_valid = any VC non-empty.
- Grant lock:
  - When out_valid && !out_ready, the grant is held in lock_vc. The next cycle presents the same VC and flit, even if a higher-priority VC fills.
  - The lock clears on handshake.
- Dequeue: when out_valid && out_ready, increment rd_ptr[grant] and decrement count[grant]. rr_ptr <= grant+1 modulo NUM_VC.
- Simultaneous enqueue and dequeue on the same VC: count is unchanged and both pointers advance. in_ready uses the pre-dequeue count, so a full VC does not accept a write in the cycle it drains. There is no full-bypass.
- Credit return: the cycle after each dequeue handshake, crd_rtn=1 and crd_rtn_vc = the dequeued VC. At most one credit per cycle. Upstream initial credits are DEPTH per VC.
- Empty bypass: none. A flit written in cycle N is visible on out_* no earlier than cycle N+1.

## Timing
- Reset (asynchronous assert, synchronous deassert handled externally):
  - All counts, pointers, rr_ptr, lock and overflow_err = 0.
  - out_valid=0, crd_rtn=0, crd_rtn_vc=0, out_vc_id=0, occupancy=0, in_ready=1.
  - out_flit is don't-care while out_valid=0.
- Reset mid-operation flushes all stored flits with no credit returns. Upstream credit counters must also be reset.
- Latency: enqueue to out_valid = 1 cycle. Dequeue handshake to crd_rtn = 1 cycle.
- out_flit, out_vc_id and out_valid come from registered state with combinational arbitration; there is no combinational path from in_* to out_*.
- out_valid must not drop, and out_vc_id and out_flit must not change, while out_valid && !out_ready.
- Throughput: 1 flit/cycle in and 1 flit/cycle out, sustained.

## Test plan
- Single flit: VC2 flit 0xA5 at cycle 0, out_ready=1 -> out_valid and out_vc_id=2 with 0xA5 at cycle 1; crd_rtn=1, crd_rtn_vc=2 at cycle 2; occupancy returns to 0.
- Fill and overflow, DEPTH=4: five flits to VC1, out_ready=0 -> in_ready=0 after the 4th; the 5th is dropped; overflow_err=1 and stays 1; occupancy[VC1]=4.
- Round-robin: VCs 0–3 each hold 2 flits, out_ready=1 -> grant order 0,1,2,3,0,1,2,3; exactly 8 crd_rtn pulses with matching VCs.
- Grant lock: VC3 granted with out_ready=0 for 3 cycles while VC0 fills -> out_vc_id stays 3 with a stable flit; after the handshake the next grant is VC0.
- Wrap and full-drain: VC0 full, then enqueue and dequeue in the same cycle -> write refused (in_ready=0); 12 further push/pop pairs with pointers wrapping -> FIFO order preserved.
- Asynchronous reset with 3 flits held -> out_valid=0 and occupancy=0 immediately; no crd_rtn after release.
